// File: rtl/design_24_result_fifo_if.sv
// ---------------------------------------------------------------------------
// design_24_result_fifo_if
//   Handshake bundle between design_24, the result FIFO and its consumer.
//
//   in_valid   producer -> FIFO   one result word per high cycle
//   in_data    producer -> FIFO   result word, sampled when in_valid=1
//   out_valid  FIFO -> consumer   head entry available
//   out_ready  consumer -> FIFO   consumer takes the head this cycle
//   out_data   FIFO -> consumer   head entry (show-ahead)
//
//   modport slave  : the FIFO side
//   modport master : the environment side (producer + consumer)
// ---------------------------------------------------------------------------
interface design_24_result_fifo_if #(
    parameter int W = 20
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/design_24_result_fifo.sv
// ---------------------------------------------------------------------------
// design_24_result_fifo
//   Show-ahead FIFO that buffers design_24 result words and hands them to a
//   consumer over a valid/ready handshake, so the consumer may stall without
//   losing data. Writes arriving while full are dropped and recorded in a
//   sticky overflow flag.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     clr          synchronous clear (pointers, count, overflow, acc)
//     bus          design_24_result_fifo_if.slave: in_valid/in_data,
//                  out_valid/out_ready/out_data
//     count        occupancy, 0..DEPTH
//     almost_full  count >= AFULL
//     overflow     sticky: a write was dropped
//     acc          sum of popped words mod 2^(W+8)
//                  (only when DESIGN_24_RESULT_ACC_EN is defined)
//
//   Build option: define DESIGN_24_RESULT_ACC_EN to add the pop accumulator.
// ---------------------------------------------------------------------------
module design_24_result_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    parameter int AFULL = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    design_24_result_fifo_if.slave   bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow
`ifdef DESIGN_24_RESULT_ACC_EN
    ,
    output logic [W+7:0]             acc
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop;
    logic          push;
    logic          drop;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign pop  = bus.out_valid & bus.out_ready;
    assign push = bus.in_valid & ((count < CW'(DEPTH)) | pop);
    assign drop = bus.in_valid & ~push;

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = mem[rd_ptr];
    assign almost_full   = (count >= CW'(AFULL));

    // Control state: pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage is data only and carries no reset; clr suppresses the write so
    // a word offered alongside clr never lands in the array.
    always_ff @(posedge clk) begin
        if (push && !clr && rst_n) mem[wr_ptr] <= bus.in_data;
    end

`ifdef DESIGN_24_RESULT_ACC_EN
    // Zero-extend the popped word and wrap modulo 2^(W+8).
    function automatic logic [W+7:0] acc_add(input logic [W+7:0] a,
                                             input logic [W-1:0] d);
        return a + {8'd0, d};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (pop) begin
            acc <= acc_add(acc, bus.out_data);
        end
    end
`endif

endmodule

// File: tb/tb_design_24_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_design_24_result_fifo
//   Directed and random stimulus for design_24_result_fifo, compared every
//   cycle against a queue-based reference model of the FIFO.
// ---------------------------------------------------------------------------
module tb_design_24_result_fifo;

    localparam int W     = 20;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          overflow;
`ifdef DESIGN_24_RESULT_ACC_EN
    logic [W+7:0]  acc;
`endif

    design_24_result_fifo_if #(.W(W)) bus ();

    design_24_result_fifo #(.W(W), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .bus         (bus),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow)
`ifdef DESIGN_24_RESULT_ACC_EN
        ,
        .acc         (acc)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus flags.
    logic [W-1:0]  mq[$];
    logic          m_ovf;
    logic [W+7:0]  m_acc;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every visible output with the model's current state.
    task automatic check_state(input string tag);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0)
            chk({tag, ".out_data"}, 64'(bus.out_data), 64'(mq[0]));
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".almost_full"}, 64'(almost_full), 64'(mq.size() >= AFULL));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
`ifdef DESIGN_24_RESULT_ACC_EN
        chk({tag, ".acc"}, 64'(acc), 64'(m_acc));
`endif
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle,
    // then advance the model by the same rules the FIFO must follow.
    task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                         input logic r, input logic c);
        bit p_pop, p_push;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        clr           = c;
        #4;
        check_state(tag);
        p_pop  = (mq.size() != 0) && r;
        p_push = v && ((mq.size() < DEPTH) || p_pop);
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_acc = '0;
        end else begin
            if (p_pop) begin
                m_acc = m_acc + (W+8)'(mq[0]);
                void'(mq.pop_front());
            end
            if (p_push) mq.push_back(d);
            if (v && !p_push) m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_acc = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        rst_n = 1'b1;

        // 1: single push, visible one cycle later
        cycle("t1_push", 1'b1, 20'h00001, 1'b0, 1'b0);
        cycle("t1_seen", 1'b0, '0, 1'b0, 1'b0);
        chk("t1.data_lit", 64'(bus.out_data), 64'h1);

        // 2: fill to four, almost_full from three, fifth write dropped
        cycle("t2_clr", 1'b0, '0, 1'b0, 1'b1);
        cycle("t2_w11", 1'b1, 20'h11, 1'b0, 1'b0);
        cycle("t2_w22", 1'b1, 20'h22, 1'b0, 1'b0);
        cycle("t2_w33", 1'b1, 20'h33, 1'b0, 1'b0);
        cycle("t2_w44", 1'b1, 20'h44, 1'b0, 1'b0);
        chk("t2.count_full", 64'(count), 64'd4);
        cycle("t2_w55", 1'b1, 20'h55, 1'b0, 1'b0);
        chk("t2.ovf_lit", 64'(overflow), 64'd1);
        chk("t2.count_stay", 64'(count), 64'd4);

        // 3: full with simultaneous push and pop, then drain
        cycle("t3_swap", 1'b1, 20'h66, 1'b1, 1'b0);
        chk("t3.count_lit", 64'(count), 64'd4);
        chk("t3.head_lit", 64'(bus.out_data), 64'h22);
        repeat (4) cycle("t3_drain", 1'b0, '0, 1'b1, 1'b0);
        cycle("t3_empty", 1'b0, '0, 1'b1, 1'b0);

        // 4: streaming 0..9 through, pointers wrap
        cycle("t4_clr", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle("t4_stream", 1'b1, W'(i), 1'b1, 1'b0);
        cycle("t4_tail", 1'b0, '0, 1'b1, 1'b0);
        cycle("t4_done", 1'b0, '0, 1'b1, 1'b0);

        // 5: asynchronous reset with entries stored
        cycle("t5_w1", 1'b1, 20'h101, 1'b0, 1'b0);
        cycle("t5_w2", 1'b1, 20'h102, 1'b0, 1'b0);
        cycle("t5_w3", 1'b1, 20'h103, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5.async_valid", 64'(bus.out_valid), 64'd0);
        chk("t5.async_count", 64'(count), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("t5_wabc", 1'b1, 20'hABCDE, 1'b0, 1'b0);
        chk("t5.first_lit", 64'(bus.out_data), 64'hABCDE);
        cycle("t5_pop", 1'b0, '0, 1'b1, 1'b0);

        // 6: accumulator of popped words, then clr beats a concurrent push
        cycle("t6_clr", 1'b0, '0, 1'b0, 1'b1);
        repeat (3) cycle("t6_fill", 1'b1, 20'hFFFFF, 1'b0, 1'b0);
        repeat (3) cycle("t6_pop", 1'b0, '0, 1'b1, 1'b0);
`ifdef DESIGN_24_RESULT_ACC_EN
        chk("t6.acc_lit", 64'(acc), 64'h2FFFFD);
`endif
        cycle("t6_w", 1'b1, 20'h12345, 1'b0, 1'b0);
        cycle("t6_clrpush", 1'b1, 20'h54321, 1'b0, 1'b1);
        chk("t6.count_lit", 64'(count), 64'd0);
        chk("t6.valid_lit", 64'(bus.out_valid), 64'd0);
        cycle("t6_after", 1'b0, '0, 1'b0, 1'b0);

        // Random traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", 1'($urandom_range(0, 2) != 0), W'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end
        cycle("rnd_end", 1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
